// File: rtl/calc_pkg.sv
// Shared constants for the calculator operand-entry front end: opcodes, operand width,
// FSM state encoding and the state-to-status-LED mapping.
package calc_pkg;

   localparam int CALC_W = 4;

   typedef logic [1:0] op_t;

   localparam op_t OP_ADD = 2'b00;
   localparam op_t OP_SUB = 2'b01;
   localparam op_t OP_DIV = 2'b10;
   localparam op_t OP_MUL = 2'b11;

   localparam logic [2:0] S_A     = 3'd0;
   localparam logic [2:0] S_B     = 3'd1;
   localparam logic [2:0] S_OP    = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   // One-hot entry stage for the status LEDs; dark while issuing or holding a result.
   function automatic logic [2:0] stage_of(input logic [2:0] st);
      case (st)
         S_A:     return 3'b001;
         S_B:     return 3'b010;
         S_OP:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/calc_operand_entry_if.sv
// Request bus between the operand-entry front end (master) and the calculator core (slave).
interface calc_operand_entry_if;
   import calc_pkg::*;

   logic [CALC_W-1:0] op_a;
   logic [CALC_W-1:0] op_b;
   op_t               op_sel;
   logic              req_valid;
   logic              req_ready;

   modport master (output op_a, output op_b, output op_sel, output req_valid, input req_ready);
   modport slave  (input op_a, input op_b, input op_sel, input req_valid, output req_ready);

endinterface

// File: rtl/calc_operand_entry_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, consecutive-mismatch debounce counter and a
// one-cycle pulse on each accepted press (debounced 0->1).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b00;
         level <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         pulse <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync[1];
               cnt   <= '0;
               pulse <= sync[1];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/calc_operand_entry.sv
// Operand entry front end for the 4-bit calculator: A, B, opcode via ENTER, then one
// valid/ready request. Optional divide-by-zero rejection under CALC_DIVZERO_GUARD_EN.
//
// state   | meaning
// S_A     | waiting for ENTER to capture operand A
// S_B     | waiting for ENTER to capture operand B
// S_OP    | waiting for ENTER to capture opcode
// S_ISSUE | request presented to core until accepted
// S_HOLD  | result shown; ENTER starts a new entry
module calc_operand_entry
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          sw,
   input  logic                btn_enter,
   input  logic                btn_clear,
   calc_operand_entry_if.master req,
   output logic [2:0]          stage,
   output logic                err
);

   logic              enter_p;
   logic              clear_p;
   logic [2:0]        state;
   logic [CALC_W-1:0] op_a_q;
   logic [CALC_W-1:0] op_b_q;
   op_t               op_sel_q;
   logic              req_valid_q;
   logic              divzero_block;
   logic              unused_sw;

   assign unused_sw = ^sw[7:CALC_W];

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_enter),
      .pulse (enter_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_clear),
      .pulse (clear_p)
   );

`ifdef CALC_DIVZERO_GUARD_EN
   logic err_q;

   assign divzero_block = (op_t'(sw[1:0]) == OP_DIV) && (op_b_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (clear_p) begin
         err_q <= 1'b0;
      end else if (enter_p && (state == S_OP) && divzero_block) begin
         err_q <= 1'b1;
      end else if (enter_p && (state != S_ISSUE)) begin
         err_q <= 1'b0;
      end
   end

   assign err = err_q;
`else
   assign divzero_block = 1'b0;
   assign err           = 1'b0;
`endif

   // CLEAR outranks ENTER and withdraws any pending request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_A;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_sel_q    <= OP_ADD;
         req_valid_q <= 1'b0;
      end else if (clear_p) begin
         state       <= S_A;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_sel_q    <= OP_ADD;
         req_valid_q <= 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (enter_p) begin
                  op_a_q <= sw[CALC_W-1:0];
                  state  <= S_B;
               end
            end
            S_B: begin
               if (enter_p) begin
                  op_b_q <= sw[CALC_W-1:0];
                  state  <= S_OP;
               end
            end
            S_OP: begin
               if (enter_p && !divzero_block) begin
                  op_sel_q <= op_t'(sw[1:0]);
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (req_valid_q && req.req_ready) begin
                  req_valid_q <= 1'b0;
                  state       <= S_HOLD;
               end else begin
                  req_valid_q <= 1'b1;
               end
            end
            S_HOLD: begin
               if (enter_p) begin
                  state <= S_A;
               end
            end
            default: begin
               state       <= S_A;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req.op_a      = op_a_q;
   assign req.op_b      = op_b_q;
   assign req.op_sel    = op_sel_q;
   assign req.req_valid = req_valid_q;
   assign stage         = stage_of(state);

endmodule

// File: tb/tb_calc_operand_entry.sv
// Self-checking bench for calc_operand_entry with a short debounce window.
module tb_calc_operand_entry;

   localparam int D = 4;
   localparam int PRESS_LAT = 2 + D + 1;

`ifdef CALC_DIVZERO_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sw = 8'h00;
   logic       btn_enter = 1'b0;
   logic       btn_clear = 1'b0;
   logic [2:0] stage;
   logic       err;

   calc_operand_entry_if bus ();

   calc_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .btn_enter (btn_enter),
      .btn_clear (btn_clear),
      .req       (bus),
      .stage     (stage),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit         ent;
      bit         clr;
      logic [7:0] swv;
      bit         rdy;
      logic [2:0] stg;
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] sel;
      bit         vld;
   } vec_t;

   vec_t vt[12];

   // behavioural model: entry step 0..2 = A/B/OP, 3 = request pending, 4 = holding result
   int         m_step;
   logic [3:0] m_a, m_b;
   logic [1:0] m_sel;
   bit         m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] stg, input logic [3:0] a,
                            input logic [3:0] b, input logic [1:0] sel, input bit vld, input bit e);
      check({name, ".stage"}, 32'(stage), 32'(stg));
      check({name, ".op_a"}, 32'(bus.op_a), 32'(a));
      check({name, ".op_b"}, 32'(bus.op_b), 32'(b));
      check({name, ".op_sel"}, 32'(bus.op_sel), 32'(sel));
      check({name, ".req_valid"}, 32'(bus.req_valid), 32'(vld));
      check({name, ".err"}, 32'(err), 32'(e));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      bus.req_ready = 1'b0;
      cycles(2);
      rst = 1'b0;
      cycles(1);
   endtask

   // Hold the button(s) long enough to be accepted, scramble sw after the capture point,
   // then release and let the debouncers fall back to 0.
   task automatic press(input bit ent, input bit clr, input logic [7:0] s);
      @(negedge clk);
      sw = s;
      btn_enter = ent;
      btn_clear = clr;
      cycles(PRESS_LAT + 1);
      sw = 8'($urandom);
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      cycles(PRESS_LAT + 3);
   endtask

   function automatic void model_accept(input bit rdy);
      if (m_step == 3 && rdy) m_step = 4;
   endfunction

   function automatic void model_ev(input bit ent, input bit clr, input logic [7:0] s);
      if (clr) begin
         m_step = 0; m_a = 0; m_b = 0; m_sel = 0; m_err = 0;
      end else if (ent) begin
         case (m_step)
            0: begin m_a = s[3:0]; m_step = 1; m_err = 0; end
            1: begin m_b = s[3:0]; m_step = 2; m_err = 0; end
            2: begin
               if (GUARD && s[1:0] == 2'b10 && m_b == 0) m_err = 1;
               else begin m_sel = s[1:0]; m_step = 3; m_err = 0; end
            end
            4: begin m_step = 0; m_err = 0; end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [2:0] model_stage();
      return (m_step < 3) ? 3'(1 << m_step) : 3'b000;
   endfunction

   initial begin
      bus.req_ready = 1'b0;
      vt[0]  = '{1, 0, 8'h07, 0, 3'b010, 4'h7, 4'h0, 2'd0, 0};
      vt[1]  = '{1, 0, 8'h03, 0, 3'b100, 4'h7, 4'h3, 2'd0, 0};
      vt[2]  = '{1, 0, 8'h03, 0, 3'b000, 4'h7, 4'h3, 2'd3, 1};
      vt[3]  = '{1, 0, 8'hff, 0, 3'b000, 4'h7, 4'h3, 2'd3, 1};
      vt[4]  = '{0, 0, 8'h00, 1, 3'b000, 4'h7, 4'h3, 2'd3, 0};
      vt[5]  = '{1, 0, 8'h05, 0, 3'b001, 4'h7, 4'h3, 2'd3, 0};
      vt[6]  = '{1, 0, 8'h0a, 0, 3'b010, 4'ha, 4'h3, 2'd3, 0};
      vt[7]  = '{0, 1, 8'h00, 0, 3'b001, 4'h0, 4'h0, 2'd0, 0};
      vt[8]  = '{1, 0, 8'h02, 0, 3'b010, 4'h2, 4'h0, 2'd0, 0};
      vt[9]  = '{1, 0, 8'h00, 0, 3'b100, 4'h2, 4'h0, 2'd0, 0};
      vt[10] = '{1, 0, 8'h01, 0, 3'b000, 4'h2, 4'h0, 2'd1, 1};
      vt[11] = '{1, 1, 8'h0c, 0, 3'b001, 4'h0, 4'h0, 2'd0, 0};

      do_reset();
      check_all("reset", 3'b001, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

      // table: full op, ignored enter in ISSUE, hold/re-entry, clear, clear-over-enter in ISSUE
      foreach (vt[i]) begin
         @(negedge clk);
         bus.req_ready = vt[i].rdy;
         if (vt[i].ent || vt[i].clr) press(vt[i].ent, vt[i].clr, vt[i].swv);
         else cycles(2 * PRESS_LAT);
         check_all($sformatf("vec%0d", i), vt[i].stg, vt[i].a, vt[i].b, vt[i].sel, vt[i].vld, 1'b0);
      end
      bus.req_ready = 1'b0;

      // async reset mid-debounce with ENTER held; no residual press after release
      do_reset();
      press(1, 0, 8'h09);
      @(negedge clk);
      btn_enter = 1'b1;
      cycles(3);
      #2 rst = 1'b1;
      #1;
      check_all("async_rst", 3'b001, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
      btn_enter = 1'b0;
      cycles(2);
      rst = 1'b0;
      cycles(3 * PRESS_LAT);
      check("no_residual.stage", 32'(stage), 32'(3'b001));

      // bounce: 10 cycles of toggling, then held high; one press exactly PRESS_LAT later
      do_reset();
      for (int i = 0; i < 10; i++) begin
         btn_enter = (i % 2 == 0);
         @(negedge clk);
      end
      btn_enter = 1'b1;
      begin
         int first = -1;
         for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (first < 0 && stage == 3'b010) first = i;
         end
         check("bounce.latency", 32'(first), 32'(PRESS_LAT));
         check("bounce.single", 32'(stage), 32'(3'b010));
      end
      btn_enter = 1'b0;
      cycles(2 * PRESS_LAT);

      // handshake held off for 5 cycles: request and fields frozen, then accepted once
      do_reset();
      press(1, 0, 8'h07);
      press(1, 0, 8'h03);
      press(1, 0, 8'h03);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_all($sformatf("stall%0d", i), 3'b000, 4'h7, 4'h3, 2'd3, 1'b1, 1'b0);
      end
      bus.req_ready = 1'b1;
      @(negedge clk);
      check("accept.drop", 32'(bus.req_valid), 32'(0));
      cycles(3);
      check_all("hold", 3'b000, 4'h7, 4'h3, 2'd3, 1'b0, 1'b0);
      bus.req_ready = 1'b0;

      // divide by zero
      do_reset();
      press(1, 0, 8'h05);
      press(1, 0, 8'h00);
      press(1, 0, 8'h02);
      if (GUARD) begin
         check_all("dz.reject", 3'b100, 4'h5, 4'h0, 2'd0, 1'b0, 1'b1);
         press(1, 0, 8'h01);
         check_all("dz.retry", 3'b000, 4'h5, 4'h0, 2'd1, 1'b1, 1'b0);
      end else begin
         check_all("dz.issue", 3'b000, 4'h5, 4'h0, 2'd2, 1'b1, 1'b0);
      end

      // randomized sequences against the behavioural model
      do_reset();
      m_step = 0; m_a = 0; m_b = 0; m_sel = 0; m_err = 0;
      for (int it = 0; it < 60; it++) begin
         int act;
         bit rdy;
         logic [7:0] s;
         act = int'($urandom_range(0, 9));
         rdy = 1'($urandom);
         s = 8'($urandom);
         if (($urandom & 3) == 0) s[3:0] = 4'h0;
         if (($urandom & 1) == 0) s[1:0] = 2'b10;
         @(negedge clk);
         bus.req_ready = rdy;
         model_accept(rdy);
         if (act < 7) begin press(1, 0, s); model_ev(1, 0, s); end
         else if (act < 8) begin press(0, 1, s); model_ev(0, 1, s); end
         else cycles(2 * PRESS_LAT);
         model_accept(rdy);
         check_all($sformatf("rnd%0d", it), model_stage(), m_a, m_b, m_sel, m_step == 3, m_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
